// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory over req/ack,
// and holds one returned instruction for the decoder; redirects squash any in-flight fetch.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int unsigned       PC_INC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REQ   = 2'b01,
    HOLD  = 2'b10,
    DRAIN = 2'b11
  } state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] LSB_MASK = ~ADDR_W'(2'b11);

  state_t            state_r, state_s, resume_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] tgt_r, tgt_s;
  logic [ADDR_W-1:0] instr_pc_r, instr_pc_s;
  logic [ADDR_W-1:0] redir_pc_s;
  logic [31:0]       instr_r, instr_s;
  logic              squash_r, squash_s;
  logic              req_r, req_s;
  logic              valid_r, valid_s;

  // Next-state and datapath decode; redirect outranks ack, ready and halt in every state.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    tgt_s      = tgt_r;
    squash_s   = squash_r;
    instr_s    = instr_r;
    instr_pc_s = instr_pc_r;
    valid_s    = valid_r;
    redir_pc_s = redirect_pc & LSB_MASK;
    if (halt) begin
      resume_s = IDLE;
    end else begin
      resume_s = REQ;
    end

    case (state_r)
      IDLE: begin
        if (redirect) begin
          pc_s    = redir_pc_s;
          valid_s = 1'b0;
        end else begin
          pc_s = pc_r;
        end
        state_s = resume_s;
      end
      REQ: begin
        if (redirect) begin
          // Without an ack the memory still owns the old address, so park the target.
          if (imem_ack) begin
            pc_s    = redir_pc_s;
            state_s = resume_s;
          end else begin
            tgt_s    = redir_pc_s;
            squash_s = 1'b1;
            state_s  = DRAIN;
          end
        end else if (imem_ack && !squash_r) begin
          instr_s    = imem_rdata;
          instr_pc_s = pc_r;
          valid_s    = 1'b1;
          pc_s       = pc_r + PC_STEP;
          state_s    = HOLD;
        end else begin
          state_s = REQ;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_s    = redir_pc_s;
          valid_s = 1'b0;
          state_s = resume_s;
        end else if (instr_ready) begin
          valid_s = 1'b0;
          state_s = resume_s;
        end else begin
          state_s = HOLD;
        end
      end
      DRAIN: begin
        if (redirect && imem_ack) begin
          pc_s     = redir_pc_s;
          squash_s = 1'b0;
          state_s  = resume_s;
        end else if (redirect) begin
          tgt_s   = redir_pc_s;
          state_s = DRAIN;
        end else if (imem_ack) begin
          pc_s     = tgt_r;
          squash_s = 1'b0;
          state_s  = resume_s;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s  = IDLE;
        squash_s = 1'b0;
        valid_s  = 1'b0;
      end
    endcase

    req_s = (state_s == REQ) || (state_s == DRAIN);
  end

  // State, PC and instruction buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      tgt_r      <= RESET_PC;
      squash_r   <= 1'b0;
      req_r      <= 1'b0;
      instr_r    <= 32'h0000_0000;
      instr_pc_r <= {ADDR_W{1'b0}};
      valid_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      tgt_r      <= tgt_s;
      squash_r   <= squash_s;
      req_r      <= req_s;
      instr_r    <= instr_s;
      instr_pc_r <= instr_pc_s;
      valid_r    <= valid_s;
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = valid_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a memory model with random wait states feeds the DUT,
// and a monitor compares every accepted instruction against an address-stream reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, halt, redirect, imem_ack, instr_ready, imem_req, instr_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, instr_pc;

  logic        halt8, redirect8, ready8, req8, ack8, valid8;
  logic [7:0]  rpc8, addr8, ipc8;
  logic [31:0] rdata8, instr8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepts = 0;
  bit zero_wait = 1'b1;
  bit did_reset = 1'b0;
  int acc_cyc[$];

  typedef struct {
    int          c;
    logic [31:0] tgt;
  } redir_t;
  redir_t      redir_q[$];
  logic [7:0]  pc8_q[$];
  logic [31:0] d8_q[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC), .PC_INC(4)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .PC_INC(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .halt(halt8), .redirect(redirect8), .redirect_pc(rpc8),
    .imem_req(req8), .imem_addr(addr8), .imem_ack(ack8), .imem_rdata(rdata8),
    .instr(instr8), .instr_pc(ipc8), .instr_valid(valid8), .instr_ready(ready8)
  );

  // zero-wait memory for the narrow instance
  assign ack8   = req8;
  assign rdata8 = {24'h80_0000, addr8};

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h8000_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: random wait states, acks only while a request is up, checks address stability.
  initial begin : mem
    bit          busy;
    bit          acked;
    int          wcnt;
    logic [31:0] raddr;
    busy = 1'b0; acked = 1'b0; wcnt = 0; raddr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        imem_ack = 1'b0; busy = 1'b0; acked = 1'b0;
      end else if (imem_req) begin
        if (!busy || acked) begin
          busy  = 1'b1;
          raddr = imem_addr;
          wcnt  = zero_wait ? 0 : int'($urandom_range(0, 5));
          chk("req_start_while_halt", 32'(halt), 32'd0);
        end
        if (wcnt == 0) begin
          chk("imem_addr_stable", imem_addr, raddr);
          imem_ack   = 1'b1;
          imem_rdata = memf(imem_addr);
          acked      = 1'b1;
        end else begin
          wcnt--;
          imem_ack   = 1'b0;
          imem_rdata = $urandom;
          acked      = 1'b0;
        end
      end else begin
        imem_ack = 1'b0; busy = 1'b0; acked = 1'b0;
      end
    end
  end

  // Monitor: the decoder must see the word at exp_pc; a redirect restarts the stream at its target.
  initial begin : mon
    logic [31:0] exp_pc;
    logic [31:0] pi, ppc;
    bit          pv, pcons;
    exp_pc = RESET_PC; pi = 32'h0; ppc = 32'h0; pv = 1'b0; pcons = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_pc = RESET_PC;
        pv     = 1'b0;
      end else begin
        if (pv && !pcons) begin
          chk("hold_valid", 32'(instr_valid), 32'd1);
          chk("hold_instr", instr, pi);
          chk("hold_pc", instr_pc, ppc);
        end
        if (instr_valid) chk("req_while_valid", 32'(imem_req), 32'd0);
        pcons = 1'b0;
        if (redir_q.size() > 0 && redir_q[0].c == cyc) begin
          exp_pc = redir_q[0].tgt;
          void'(redir_q.pop_front());
          pcons = 1'b1;
        end else if (instr_valid && instr_ready) begin
          chk("instr_pc", instr_pc, exp_pc);
          chk("instr", instr, memf(exp_pc));
          exp_pc = exp_pc + 32'd4;
          accepts++;
          acc_cyc.push_back(cyc);
          pcons = 1'b1;
        end
        pv = instr_valid; pi = instr; ppc = instr_pc;
      end
    end
  end

  initial begin : mon8
    forever begin
      @(negedge clk);
      if (rst_n && valid8 && ready8) begin
        pc8_q.push_back(ipc8);
        d8_q.push_back(instr8);
      end
    end
  end

  initial begin : stim
    redir_t r;
    rst_n = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    halt8 = 1'b1; redirect8 = 1'b0; rpc8 = 8'h00; ready8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // zero-wait memory, always-ready decoder: back-to-back throughput; wrap test on dut8
    zero_wait   = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      redirect8 = (i == 2);
      rpc8      = 8'hFD;
      if (i == 4) halt8 = 1'b0;
    end
    chk("p1_accept_count", 32'(acc_cyc.size() >= 15), 32'd1);
    if (acc_cyc.size() >= 11) chk("p1_spacing", 32'(acc_cyc[10] - acc_cyc[1]), 32'd18);
    chk("wrap_count", 32'(pc8_q.size() >= 2), 32'd1);
    if (pc8_q.size() >= 2) begin
      chk("wrap_pc0", 32'(pc8_q[0]), 32'h0000_00FC);
      chk("wrap_d0", d8_q[0], 32'h8000_00FC);
      chk("wrap_pc1", 32'(pc8_q[1]), 32'h0000_0000);
      chk("wrap_d1", d8_q[1], 32'h8000_0000);
    end

    // randomized phase with wait states, stalls, halts, redirects and one mid-fetch reset
    zero_wait = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      instr_ready = ($urandom_range(0, 9) < 7);
      if (halt) begin
        if ($urandom_range(0, 7) == 0) halt = 1'b0;
      end else begin
        if ($urandom_range(0, 31) == 0) halt = 1'b1;
      end
      if (i >= 2000 && !did_reset && imem_req) begin
        did_reset = 1'b1;
        redirect  = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_imem_req", 32'(imem_req), 32'd0);
        chk("midrst_instr_valid", 32'(instr_valid), 32'd0);
        chk("midrst_imem_addr", imem_addr, RESET_PC);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
      end else begin
        redirect    = ($urandom_range(0, 7) == 0);
        redirect_pc = $urandom;
        if (redirect) begin
          r.c   = cyc;
          r.tgt = redirect_pc & 32'hFFFF_FFFC;
          redir_q.push_back(r);
        end
      end
    end
    @(posedge clk);
    #2;
    redirect = 1'b0;
    repeat (2) @(posedge clk);

    chk("mid_reset_done", 32'(did_reset), 32'd1);
    chk("redirects_consumed", 32'(redir_q.size()), 32'd0);
    chk("liveness", 32'(accepts >= 150), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
